// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the multi-approach traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Phase duration timer: counts enabled cycles from 0 and flags the last cycle of a phase.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] dur_eff_s;

  // A zero duration still occupies one cycle.
  always_comb begin
    dur_eff_s = (dur_i == {CNT_W{1'b0}}) ? CNT_W'(1) : dur_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    dur_d = dur_q;
    if (load_i) begin
      cnt_d = {CNT_W{1'b0}};
      dur_d = dur_eff_s;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
      dur_q <= dur_eff_s;
    end else begin
      cnt_q <= cnt_d;
      dur_q <= dur_d;
    end
  end

  assign done_o = (cnt_q == (dur_q - CNT_W'(1)));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic phase controller: rotating green/yellow/all-red right-of-way,
// latched pedestrian walk requests, enable freeze and blinking-yellow flash mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 2,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CNT_W-1:0]           green_time,
  input  logic [CNT_W-1:0]           yellow_time,
  input  logic [CNT_W-1:0]           allred_time,
  input  logic [NUM_DIR-1:0]         ped_req,
  input  logic                       flash,
  output logic [3*NUM_DIR-1:0]       led,
  output logic [$clog2(NUM_DIR)-1:0] phase_idx,
  output logic [NUM_DIR-1:0]         ped_walk
);

  localparam int IDX_W = $clog2(NUM_DIR);
  localparam int BLK_W = $clog2(FLASH_HALF + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d, next_cur_s;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               walk_q, walk_d;
  logic               restart_q, restart_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               tmr_load_s, tmr_done_s;
  logic [CNT_W-1:0]   tmr_dur_s;

  // While reset is held the timer captures the green duration for the first phase.
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .load_i (tmr_load_s),
    .dur_i  (rst ? tmr_dur_s : green_time),
    .done_o (tmr_done_s)
  );

  // After leaving flash the rotation restarts at approach 0.
  always_comb begin
    if (restart_q || (cur_q == IDX_W'(NUM_DIR - 1))) begin
      next_cur_s = {IDX_W{1'b0}};
    end else begin
      next_cur_s = cur_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q | ped_req;
    walk_d      = walk_q;
    restart_d   = restart_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    tmr_load_s  = 1'b0;
    tmr_dur_s   = green_time;
    if (flash) begin
      state_d = ST_FLASH;
      if (state_q != ST_FLASH) begin
        blink_cnt_d = {BLK_W{1'b0}};
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLK_W'(FLASH_HALF - 1)) begin
        blink_cnt_d = {BLK_W{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end else if (state_q == ST_FLASH) begin
      state_d    = ST_ALLRED;
      tmr_load_s = 1'b1;
      tmr_dur_s  = allred_time;
      restart_d  = 1'b1;
    end else if (en && tmr_done_s) begin
      tmr_load_s = 1'b1;
      case (state_q)
        ST_GREEN: begin
          state_d   = ST_YELLOW;
          tmr_dur_s = yellow_time;
        end
        ST_YELLOW: begin
          state_d   = ST_ALLRED;
          tmr_dur_s = allred_time;
        end
        ST_ALLRED: begin
          // A request arriving on the entry edge is served by this green.
          state_d        = ST_GREEN;
          tmr_dur_s      = green_time;
          cur_d          = next_cur_s;
          restart_d      = 1'b0;
          walk_d         = pend_d[next_cur_s];
          pend_d[next_cur_s] = 1'b0;
        end
        default: begin
          state_d   = ST_GREEN;
          tmr_dur_s = green_time;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_GREEN;
      cur_q       <= {IDX_W{1'b0}};
      pend_q      <= {NUM_DIR{1'b0}};
      walk_q      <= 1'b0;
      restart_q   <= 1'b0;
      blink_cnt_q <= {BLK_W{1'b0}};
      blink_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      walk_q      <= walk_d;
      restart_q   <= restart_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  always_comb begin
    led      = {(3*NUM_DIR){1'b0}};
    ped_walk = {NUM_DIR{1'b0}};
    for (int i = 0; i < NUM_DIR; i++) begin
      case (state_q)
        ST_GREEN:  led[3*i +: 3] = (cur_q == IDX_W'(i)) ? LAMP_GRN : LAMP_RED;
        ST_YELLOW: led[3*i +: 3] = (cur_q == IDX_W'(i)) ? LAMP_YEL : LAMP_RED;
        ST_ALLRED: led[3*i +: 3] = LAMP_RED;
        ST_FLASH:  led[3*i +: 3] = blink_on_q ? LAMP_YEL : LAMP_OFF;
        default:   led[3*i +: 3] = LAMP_RED;
      endcase
    end
    if ((state_q == ST_GREEN) && walk_q) begin
      ped_walk[cur_q] = 1'b1;
    end else begin
      ped_walk = {NUM_DIR{1'b0}};
    end
  end

  assign phase_idx = cur_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// remaining-time reference model of the phase sequence.
module tb_traffic_phase_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int FH = 4;

  logic          clk = 1'b0;
  logic          rst, en, flash;
  logic [CW-1:0] g_t, y_t, a_t;
  logic [N-1:0]  ped_req;
  logic [3*N-1:0] led;
  logic [1:0]    phase_idx;
  logic [N-1:0]  ped_walk;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.NUM_DIR(N), .CNT_W(CW), .FLASH_HALF(FH)) dut (
    .clk(clk), .rst(rst), .en(en),
    .green_time(g_t), .yellow_time(y_t), .allred_time(a_t),
    .ped_req(ped_req), .flash(flash),
    .led(led), .phase_idx(phase_idx), .ped_walk(ped_walk)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase kind (0 green, 1 yellow, 2 all-red, 3 flash) with cycles remaining.
  int       m_st, m_cur, m_rem, m_tick;
  bit [N-1:0] m_pend;
  bit       m_walk, m_restart;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_edge();
    bit [N-1:0] p;
    if (!rst) begin
      m_st = 0; m_cur = 0; m_rem = eff(g_t); m_pend = '0;
      m_walk = 1'b0; m_restart = 1'b0; m_tick = 0;
      return;
    end
    p = m_pend | ped_req;
    if (flash) begin
      if (m_st != 3) begin m_st = 3; m_tick = 0; end
      else m_tick++;
    end else if (m_st == 3) begin
      m_st = 2; m_rem = eff(a_t); m_restart = 1'b1;
    end else if (en) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_st == 0) begin m_st = 1; m_rem = eff(y_t); end
        else if (m_st == 1) begin m_st = 2; m_rem = eff(a_t); end
        else begin
          m_cur = m_restart ? 0 : (m_cur + 1) % N;
          m_restart = 1'b0;
          m_st = 0; m_rem = eff(g_t);
          m_walk = p[m_cur];
          p[m_cur] = 1'b0;
        end
      end
    end
    m_pend = p;
  endtask

  task automatic check_outputs();
    logic [3*N-1:0] e_led;
    logic [N-1:0]   e_walk;
    e_walk = '0;
    for (int i = 0; i < N; i++) begin
      if (m_st == 3)      e_led[3*i +: 3] = (((m_tick / FH) % 2) == 0) ? 3'b010 : 3'b000;
      else if (m_st == 2) e_led[3*i +: 3] = 3'b100;
      else if (i == m_cur) e_led[3*i +: 3] = (m_st == 0) ? 3'b001 : 3'b010;
      else                e_led[3*i +: 3] = 3'b100;
    end
    if (m_st == 0 && m_walk) e_walk[m_cur] = 1'b1;
    chk("led", 32'(led), 32'(e_led));
    chk("phase_idx", 32'(phase_idx), 32'(m_cur));
    chk("ped_walk", 32'(ped_walk), 32'(e_walk));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    ped_req = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_for(input int st, input int cur, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_st == st && m_cur == cur) found = 1'b1;
      else cyc();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  int flash_left;

  initial begin
    rst = 1'b0; en = 1'b1; flash = 1'b0; ped_req = '0;
    g_t = 8'd15; y_t = 8'd3; a_t = 8'd3;
    run(2);
    chk("reset_led", 32'(led), 32'(12'b100100100001));
    chk("reset_idx", 32'(phase_idx), 32'd0);
    chk("reset_walk", 32'(ped_walk), 32'd0);
    rst = 1'b1;

    // Walk request for dir1 during GREEN(0), then a second one during GREEN(1).
    run(5);
    ped_req = 4'b0010;
    cyc();
    wait_for(0, 1, "wait_g1_a");
    chk("walk_dir1_first", 32'(ped_walk), 32'h2);
    run(3);
    ped_req = 4'b0010;
    cyc();
    chk("walk_dir1_hold", 32'(ped_walk), 32'h2);
    wait_for(1, 1, "wait_y1_a");
    chk("walk_off_yellow", 32'(ped_walk), 32'h0);
    wait_for(0, 1, "wait_g1_b");
    chk("walk_dir1_second", 32'(ped_walk), 32'h2);
    wait_for(1, 1, "wait_y1_b");
    wait_for(0, 1, "wait_g1_c");
    chk("walk_dir1_none", 32'(ped_walk), 32'h0);

    // Freeze mid-green, then let it finish.
    wait_for(0, 2, "wait_g2");
    run(4);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(40);

    // Zero-length green, then short 2/1/1 durations.
    g_t = 8'd0;
    run(40);
    g_t = 8'd2; y_t = 8'd1; a_t = 8'd1;
    run(40);

    // Flash entered mid-yellow, then released.
    g_t = 8'd5; y_t = 8'd4; a_t = 8'd3;
    wait_for(1, 1, "wait_y_flash");
    flash = 1'b1;
    run(20);
    flash = 1'b0;
    run(30);

    // Reset during ALLRED following dir2, with dir0 request pending.
    g_t = 8'd3; y_t = 8'd2; a_t = 8'd4;
    wait_for(0, 1, "wait_g1_rst");
    ped_req = 4'b0001;
    cyc();
    wait_for(2, 2, "wait_ar2");
    rst = 1'b0;
    cyc();
    chk("rst_mid_led", 32'(led), 32'(12'b100100100001));
    chk("rst_mid_idx", 32'(phase_idx), 32'd0);
    rst = 1'b1;
    run(3);
    chk("rst_pend_cleared", 32'(ped_walk), 32'h0);
    run(20);

    // Randomized traffic.
    flash_left = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        g_t = 8'($urandom_range(0, 6));
        y_t = 8'($urandom_range(0, 4));
        a_t = 8'($urandom_range(0, 4));
      end
      for (int d = 0; d < N; d++) ped_req[d] = ($urandom_range(0, 19) == 0);
      if (flash_left == 0 && $urandom_range(0, 299) == 0) flash_left = $urandom_range(3, 20);
      flash = (flash_left > 0);
      if (flash_left > 0) flash_left--;
      en  = flash ? 1'b1 : ($urandom_range(0, 99) < 85);
      rst = ($urandom_range(0, 499) != 0);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-direction traffic-light phase controller, the next generation of the team's two-way fixed-timing controller. It cycles right-of-way across `NUM_DIR` approaches with run-time programmable green, yellow and all-red durations. It adds latched pedestrian-walk requests, an enable/freeze control and a blinking-yellow flash mode. It sits between the intersection config registers and the per-approach lamp drivers.

## Interface
- `NUM_DIR`, default 2: number of approaches, legal 2..4.
- `CNT_W`, default 8: width of duration inputs and the internal phase counter.
- `FLASH_HALF`, default 4: cycles per half-period of the flash blink.
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  1 = timer advances; 0 = state and counter hold.
- `green_time`  in  CNT_W  green duration in cycles.
- `yellow_time`  in  CNT_W  yellow duration in cycles.
- `allred_time`  in  CNT_W  all-red clearance duration in cycles.
- `ped_req`  in  NUM_DIR  per-approach walk request; a one-cycle pulse is enough.
- `flash`  in  1  level; 1 = flash mode.
- `led`  out  3*NUM_DIR  per approach i, bits [3i+2:3i] are one-hot lamps: 100 red, 010 yellow, 001 green.
- `phase_idx`  out  clog2(NUM_DIR)  current approach pointer `cur`.
- `ped_walk`  out  NUM_DIR  walk lamp per approach.

## Operation
- States: GREEN, YELLOW, ALLRED, FLASH. Pointer `cur` selects the approach that owns right-of-way.
- Sequence: GREEN(cur) → YELLOW(cur) → ALLRED → GREEN(cur+1). `cur` wraps from NUM_DIR-1 to 0 and increments on the ALLRED→GREEN transition.
- Duration sampling:
  - Each duration is sampled into the phase timer on state entry. Changes to the inputs mid-phase take effect at the next entry.
  - A duration of 0 is treated as 1.
- Phase timing:
  - The counter runs from 0 and the state exits when count == dur-1, so each phase lasts exactly dur enabled cycles.
  - `en`=0 freezes the counter and state. The outputs stay stable.
- Lamp outputs:
  - GREEN: `led[cur]`=001; all other approaches 100.
  - YELLOW: `led[cur]`=010; all other approaches 100.
  - ALLRED: all approaches 100.
- Pedestrian walk:
  - `ped_req[i]` sets a sticky pending bit `pend[i]`.
  - On entry to GREEN(i), `pend[i]` is copied into `walk_i` and cleared.
  - `ped_walk[i]` = `walk_i` while in GREEN(i); otherwise 0.
  - A request for i arriving during GREEN(i) stays pending for the next round.
  - A request on the same cycle as GREEN(i) entry is captured for the current green.
- Flash mode:
  - `flash`=1 forces FLASH on the next edge, regardless of `en` or the current state.
  - In FLASH, all approaches alternate between 010 and 000, every FLASH_HALF cycles, starting with 010. `ped_walk`=0.
  - When `flash` returns to 0, the block enters ALLRED with a fresh `allred_time`, then goes to GREEN(0).
  - Pending requests are retained through flash.
- Priority: `rst` > `flash` > terminal count > hold.

## Timing
- Outputs are decoded combinationally from registered state and `cur`, so they change on the same edge as the state.
- Reset (`rst`=0 at an edge): state=GREEN, `cur`=0, count=0, `pend`=0, `walk`=0.
  - `led` = approach 0 at 001, all others at 100.
  - `phase_idx`=0, `ped_walk`=0.
  - The first green after release lasts `green_time` cycles.
- A reset mid-phase or mid-flash aborts immediately on that edge. Nothing resumes.
- Cycle time with en=1: NUM_DIR × (green + yellow + allred).
- Entry into flash lags `flash`=1 by one edge. Exit from flash lags `flash`=0 by one edge.

## Structure
- Package `traffic_pkg` holds:
  - the state enum;
  - lamp constants `LAMP_RED`=100, `LAMP_YEL`=010, `LAMP_GRN`=001, `LAMP_OFF`=000.
- Sub-module `phase_timer`: a CNT_W-bit counter with load, hold and `done` (count == dur-1, with zero mapped to 1).
- The flash blink counter lives in the top module.

## Test plan
- NUM_DIR=2, green=15, yellow=3, allred=3, en=1, after reset: dir0 001 for 15 cycles, 010 for 3, all-red 3, then dir1 001. The full period is 42 cycles and `phase_idx` toggles 0→1→0.
- NUM_DIR=4, durations 2/1/1: `phase_idx` walks 0,1,2,3,0 with 4 cycles per approach. Exactly one approach is non-red at any time.
- `ped_req[1]` pulsed during GREEN(0): `ped_walk[1]`=1 for all of GREEN(1), and 0 otherwise. A second pulse during GREEN(1) produces walk only on the next GREEN(1).
- `flash`=1 mid-YELLOW with FLASH_HALF=4: all lamps go 010×4, 000×4, repeating. After `flash`=0: all-red for `allred_time`, then GREEN(0).
- `en`=0 for 10 cycles mid-green: outputs frozen, and the green completes with its remaining count afterwards. `green_time`=0 gives a 1-cycle green.
- `rst`=0 asserted mid-ALLRED on dir2: the next edge shows dir0 green, `phase_idx`=0 and `pend` cleared.
